// File: rtl/tlul_pkg.sv
// Minimal TL-UL type set shared by the host sequencer and its bench:
// bus widths, A/D opcodes and the host/device channel structs.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_seq_pkg.sv
// Command entry, FSM state encoding and response-opcode helper for the
// TL-UL request sequencer.
package tlul_seq_pkg;
  import tlul_pkg::*;

  localparam int SeqPortW = 2;
  localparam int SeqGapW  = 8;

  localparam logic [TL_SZW-1:0] ASize = 2'd2;

  typedef struct packed {
    logic [SeqPortW-1:0] port;
    tl_a_op_e            opcode;
    logic [TL_AW-1:0]    addr;
    logic [TL_DW-1:0]    data;
    logic [TL_DBW-1:0]   mask;
    logic [TL_AIW-1:0]   source;
    logic                exp_err;
    logic                chk_data;
    logic [TL_DW-1:0]    exp_data;
    logic [SeqGapW-1:0]  gap;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    REQ,
    RSP,
    DONE
  } seq_state_e;

  function automatic tl_d_op_e exp_d_opcode(input tl_a_op_e op);
    return (op == Get) ? AccessAckData : AccessAck;
  endfunction

endpackage

// File: rtl/tlul_seq_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module tlul_seq_fifo
  import tlul_seq_pkg::*;
#(
  parameter int Depth = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en_i,
  input  cmd_t wdata_i,
  input  logic rd_en_i,
  output cmd_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PtrW = $clog2(Depth);

  cmd_t            mem_q [Depth];
  logic [PtrW:0]   wptr_q;
  logic [PtrW:0]   rptr_q;
  logic            rd_ok;
  logic            wr_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign rd_ok   = rd_en_i && !empty_o;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_ok   = wr_en_i && (!full_o || rd_ok);
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tlul_req_sequencer.sv
// TL-UL host command engine: replays queued A-channel requests one at a time
// on a selected host port and scores each D response.
module tlul_req_sequencer
  import tlul_pkg::*;
  import tlul_seq_pkg::*;
#(
  parameter int NumPorts = 4,
  parameter int Depth    = 16,
  parameter int GapW     = 8,
  parameter int Timeout  = 1024,
  parameter int CntW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  cmd_t             cmd_i,
  input  logic             start_i,
  output tl_h2d_t          tl_h2d_o [NumPorts],
  input  tl_d2h_t          tl_d2h_i [NumPorts],
  output logic             busy_o,
  output logic             done_o,
  output logic [CntW-1:0]  pass_cnt_o,
  output logic [CntW-1:0]  fail_cnt_o,
  output logic [CntW-1:0]  tmo_cnt_o,
  output logic [TL_DW-1:0] last_rdata_o
);

  localparam int TW = $clog2(Timeout) + 1;

  seq_state_e       state_q;
  cmd_t             cur_q;
  cmd_t             head;
  logic [GapW-1:0]  gcnt_q;
  logic [TW-1:0]    tcnt_q;
  logic [CntW-1:0]  pass_q, fail_q, tmo_q;
  logic [TL_DW-1:0] rdata_q;

  logic    fifo_full, fifo_empty;
  logic    go, in_req, in_rsp, complete, tmo_hit, finish, pop, push, resp_bad;
  tl_d2h_t sel_d2h;
  logic    unused_d2h;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign sel_d2h  = tl_d2h_i[cur_q.port];
  assign in_req   = (state_q == REQ);
  assign in_rsp   = (state_q == RSP);
  assign go       = start_i && (state_q == IDLE || state_q == DONE);
  assign complete = (in_req && sel_d2h.a_ready && sel_d2h.d_valid) ||
                    (in_rsp && sel_d2h.d_valid);
  assign tmo_hit  = (in_req || in_rsp) && !complete && (tcnt_q == TW'(Timeout - 1));
  assign finish   = complete || tmo_hit;
  assign pop      = !fifo_empty && (go || finish);
  assign push     = cmd_valid_i && cmd_ready_o;
  assign cmd_ready_o = !fifo_full || pop;

  assign resp_bad = (sel_d2h.d_opcode != exp_d_opcode(cur_q.opcode)) ||
                    (sel_d2h.d_error != cur_q.exp_err) ||
                    (cur_q.chk_data && (sel_d2h.d_data != cur_q.exp_data));

  assign unused_d2h = ^{sel_d2h.d_param, sel_d2h.d_size, sel_d2h.d_source, sel_d2h.d_sink};

  tlul_seq_fifo #(.Depth(Depth)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (push),
    .wdata_i (cmd_i),
    .rd_en_i (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Only the port named by the active command ever sees a_valid/d_ready.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      tl_h2d_o[p] = '0;
      if ((in_req || in_rsp) && (cur_q.port == SeqPortW'(p))) begin
        tl_h2d_o[p].d_ready = 1'b1;
        if (in_req) begin
          tl_h2d_o[p].a_valid   = 1'b1;
          tl_h2d_o[p].a_opcode  = cur_q.opcode;
          tl_h2d_o[p].a_param   = 3'd0;
          tl_h2d_o[p].a_size    = ASize;
          tl_h2d_o[p].a_source  = cur_q.source;
          tl_h2d_o[p].a_address = cur_q.addr;
          tl_h2d_o[p].a_mask    = cur_q.mask;
          tl_h2d_o[p].a_data    = cur_q.data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) cur_q <= head;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gcnt_q  <= '0;
      tcnt_q  <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            pass_q <= '0;
            fail_q <= '0;
            tmo_q  <= '0;
            if (fifo_empty) begin
              state_q <= DONE;
            end else begin
              state_q <= GAP;
              gcnt_q  <= GapW'(head.gap);
            end
          end
        end
        GAP: begin
          if (gcnt_q == '0) begin
            state_q <= REQ;
            tcnt_q  <= '0;
          end else begin
            gcnt_q <= gcnt_q - 1'b1;
          end
        end
        REQ, RSP: begin
          tcnt_q <= tcnt_q + 1'b1;
          if (finish) begin
            if (complete) begin
              rdata_q <= sel_d2h.d_data;
              if (resp_bad) fail_q <= sat_inc(fail_q);
              else          pass_q <= sat_inc(pass_q);
            end else begin
              tmo_q <= sat_inc(tmo_q);
            end
            if (fifo_empty) begin
              state_q <= DONE;
            end else begin
              state_q <= GAP;
              gcnt_q  <= GapW'(head.gap);
            end
          end else if (in_req && sel_d2h.a_ready) begin
            state_q <= RSP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = (state_q == GAP) || (state_q == REQ) || (state_q == RSP);
  assign done_o       = (state_q == DONE);
  assign pass_cnt_o   = pass_q;
  assign fail_cnt_o   = fail_q;
  assign tmo_cnt_o    = tmo_q;
  assign last_rdata_o = rdata_q;

endmodule

// File: tb/tb_tlul_req_sequencer.sv
// Directed bench for tlul_req_sequencer with a small per-port TL-UL device
// responder whose accept delay, split D beat and response fields are tunable.
module tb_tlul_req_sequencer;
  import tlul_pkg::*;
  import tlul_seq_pkg::*;

  localparam int NP   = 4;
  localparam int CW   = 16;
  localparam logic [31:0] HWCFG0_OFFSET = 32'h0000_0004;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  cmd_t             cmd;
  logic             start;
  tl_h2d_t          h2d [NP];
  tl_d2h_t          d2h [NP];
  logic             busy, done;
  logic [CW-1:0]    pass_cnt, fail_cnt, tmo_cnt;
  logic [TL_DW-1:0] last_rdata;

  // responder controls
  logic [NP-1:0]    en = '1;
  int               dly = 0;
  logic             split = 1'b0;
  tl_d_op_e         rsp_op = AccessAck;
  logic             rsp_err = 1'b0;
  logic [TL_DW-1:0] rsp_data = '0;
  logic             spur0 = 1'b0;

  // responder / monitor state
  int               vcnt [NP] = '{default: 0};
  logic [NP-1:0]    pend = '0;
  int               cyc = 0;
  int               av_cnt [NP] = '{default: 0};
  int               acc_cyc [NP] = '{default: 0};
  int               prev_acc [NP] = '{default: 0};
  logic [TL_AW-1:0] la_addr = '0;
  logic [TL_DW-1:0] la_data = '0;
  logic [1:0]       la_size = '0;
  logic [2:0]       la_param = '1;

  int n_tests = 0;
  int n_fail  = 0;

  tlul_req_sequencer #(
    .NumPorts(NP), .Depth(16), .GapW(8), .Timeout(16), .CntW(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_i        (cmd),
    .start_i      (start),
    .tl_h2d_o     (h2d),
    .tl_d2h_i     (d2h),
    .busy_o       (busy),
    .done_o       (done),
    .pass_cnt_o   (pass_cnt),
    .fail_cnt_o   (fail_cnt),
    .tmo_cnt_o    (tmo_cnt),
    .last_rdata_o (last_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic ar;
    ar = 1'b0;
    for (int p = 0; p < NP; p++) begin
      d2h[p] = '0;
      ar = en[p] && h2d[p].a_valid && (vcnt[p] >= dly);
      d2h[p].a_ready  = ar;
      d2h[p].d_valid  = (en[p] && (split ? pend[p] : ar)) || ((p == 0) && spur0);
      d2h[p].d_opcode = rsp_op;
      d2h[p].d_error  = rsp_err;
      d2h[p].d_data   = rsp_data;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int p = 0; p < NP; p++) begin
      if (h2d[p].a_valid) av_cnt[p] <= av_cnt[p] + 1;
      if (h2d[p].a_valid && !d2h[p].a_ready) vcnt[p] <= vcnt[p] + 1;
      else                                   vcnt[p] <= 0;
      if (h2d[p].a_valid && d2h[p].a_ready) begin
        prev_acc[p] <= acc_cyc[p];
        acc_cyc[p]  <= cyc;
        la_addr     <= h2d[p].a_address;
        la_data     <= h2d[p].a_data;
        la_size     <= h2d[p].a_size;
        la_param    <= h2d[p].a_param;
      end
      if (!rst) pend[p] <= 1'b0;
      else if (split && h2d[p].a_valid && d2h[p].a_ready) pend[p] <= 1'b1;
      else if (d2h[p].d_valid && h2d[p].d_ready) pend[p] <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input cmd_t c);
    cmd = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (done) break;
      step();
    end
    check(tag, done, 1'b1);
  endtask

  function automatic cmd_t mk(input int port, input tl_a_op_e op, input logic [31:0] addr,
                              input logic [31:0] data, input logic exp_err, input logic chk,
                              input logic [31:0] exp_data, input int gap);
    cmd_t c;
    c          = '0;
    c.port     = SeqPortW'(port);
    c.opcode   = op;
    c.addr     = addr;
    c.data     = data;
    c.mask     = 4'hF;
    c.exp_err  = exp_err;
    c.chk_data = chk;
    c.exp_data = exp_data;
    c.gap      = SeqGapW'(gap);
    return c;
  endfunction

  initial begin
    int base, s;
    rst = 1'b0;
    cmd_valid = 1'b0;
    start = 1'b0;
    cmd = mk(0, PutFullData, 32'h1234, 32'h5678, 1'b0, 1'b0, 32'h0, 0);

    // Reset held with pushes attempted: nothing may be queued or driven
    cmd_valid = 1'b1;
    step(3);
    for (int p = 0; p < NP; p++) check($sformatf("rst_avalid%0d", p), h2d[p].a_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cnts", {pass_cnt, fail_cnt, tmo_cnt}, 48'h0);
    check("rst_rdata", last_rdata, 32'h0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    run();
    check("empty_start_done", done, 1'b1);
    check("empty_start_busy", busy, 1'b0);

    // Single write on the register port, a_ready after 2 cycles
    dly = 2; rsp_op = AccessAck; rsp_err = 1'b0;
    push(mk(3, PutFullData, HWCFG0_OFFSET, 32'hFFFF0000, 1'b0, 1'b0, 32'h0, 0));
    base = av_cnt[3];
    run();
    check("wr_busy", busy, 1'b1);
    wait_done("wr_done");
    check("wr_avalid_cycles", av_cnt[3] - base, 3);
    check("wr_pass", pass_cnt, 1);
    check("wr_fail", fail_cnt, 0);
    check("wr_addr", la_addr, HWCFG0_OFFSET);
    check("wr_data", la_data, 32'hFFFF0000);
    check("wr_size", la_size, 2'd2);
    check("wr_param", la_param, 3'd0);

    // Read with data check, D beat arrives one cycle after A accept
    dly = 0; split = 1'b1; rsp_op = AccessAckData; rsp_data = 32'hABCE;
    push(mk(1, Get, 32'h40080000, 32'h0, 1'b0, 1'b1, 32'hABCD, 0));
    run();
    wait_done("rd_done");
    check("rd_fail", fail_cnt, 1);
    check("rd_pass", pass_cnt, 0);
    check("rd_rdata", last_rdata, 32'hABCE);
    split = 1'b0;

    // Denied access: expected error passes, unexpected error fails
    rsp_op = AccessAck; rsp_err = 1'b1; rsp_data = 32'h0;
    push(mk(0, PutFullData, 32'h20004000, 32'h1, 1'b1, 1'b0, 32'h0, 0));
    push(mk(0, PutFullData, 32'h20004000, 32'h1, 1'b0, 1'b0, 32'h0, 0));
    run();
    wait_done("deny_done");
    check("deny_pass", pass_cnt, 1);
    check("deny_fail", fail_cnt, 1);

    // Timeout on a silent port 2, spurious D beats on port 0, then a good command
    rsp_err = 1'b0; en[2] = 1'b0; spur0 = 1'b1;
    push(mk(2, PutFullData, 32'h30000000, 32'h2, 1'b0, 1'b0, 32'h0, 0));
    push(mk(1, PutFullData, 32'h30000010, 32'h3, 1'b0, 1'b0, 32'h0, 0));
    base = av_cnt[2];
    run();
    wait_done("tmo_done");
    check("tmo_req_cycles", av_cnt[2] - base, 16);
    check("tmo_cnt", tmo_cnt, 1);
    check("tmo_pass", pass_cnt, 1);
    check("tmo_fail", fail_cnt, 0);
    check("tmo_p0_dready", h2d[0].d_ready, 1'b0);
    spur0 = 1'b0;

    // FIFO boundary: fill, drop one, push alongside the start pop
    for (int i = 0; i < 16; i++)
      push(mk(1, PutFullData, 32'h50000000 + 32'(i * 4), 32'(i), 1'b0, 1'b0, 32'h0, 3));
    check("fifo_full_ready", cmd_ready, 1'b0);
    push(mk(1, PutFullData, 32'h5000_0F00, 32'hDEAD, 1'b0, 1'b0, 32'h0, 3));
    cmd = mk(1, PutFullData, 32'h5000_0F04, 32'hBEEF, 1'b0, 1'b0, 32'h0, 3);
    cmd_valid = 1'b1;
    start = 1'b1;
    #1;
    check("fifo_ready_on_pop", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    start = 1'b0;
    wait_done("fifo_done");
    check("fifo_pass", pass_cnt, 17);
    check("fifo_last_addr", la_addr, 32'h5000_0F04);

    // Back-to-back gap=0 commands
    push(mk(1, PutFullData, 32'h60000000, 32'h7, 1'b0, 1'b0, 32'h0, 0));
    push(mk(1, PutFullData, 32'h60000004, 32'h8, 1'b0, 1'b0, 32'h0, 0));
    run();
    wait_done("b2b_done");
    check("b2b_spacing", acc_cyc[1] - prev_acc[1], 2);
    check("b2b_pass", pass_cnt, 2);

    // Reset in the middle of a stuck transaction discards the queue
    push(mk(2, PutFullData, 32'h70000000, 32'h9, 1'b0, 1'b0, 32'h0, 0));
    push(mk(2, PutFullData, 32'h70000004, 32'hA, 1'b0, 1'b0, 32'h0, 0));
    run();
    s = 0;
    step(3);
    check("mid_avalid", h2d[2].a_valid, 1'b1);
    rst = 1'b0;
    step();
    check("mid_rst_avalid", h2d[2].a_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    rst = 1'b1;
    run();
    check("mid_flush_done", done, 1'b1);
    check("mid_flush_tmo", tmo_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
